mdio_master: RTL and testbench

- Clause-22 MDIO management initiator. Drives MDC/MDIO toward the RGMII PHY (YT8511) so the design can read and write PHY registers: link status, speed, RGMII delay configuration.
- Sits in the clk_int (125 MHz) domain beside the RGMII MAC.
- Accepts one command per valid/ready handshake and serializes it as a complete MDIO frame. Returns read data, plus a turnaround-error flag, as a one-cycle response pulse.

---
 rtl/mdio_master.sv | 170 +++++++++++++++++
 tb/tb_mdio_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: serializes one read/write command per handshake into a
// full MDC/MDIO frame and returns read data plus the turnaround check as a response pulse.
module mdio_master #(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk_int,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t
);

  localparam logic [8:0] DIV_HALF = 9'(CLK_DIV);
  localparam logic [8:0] DIV_SAMP = 9'(CLK_DIV - 1);
  localparam logic [8:0] DIV_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] DIV_END  = 9'(2 * CLK_DIV - 2);
  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_END
  } state_t;

  state_t      r_state, w_state_next;
  logic [5:0]  r_bit_cnt, w_bit_cnt_next, w_field_last;
  logic [8:0]  r_div_cnt, w_div_cnt_next;
  logic [31:0] r_tx_sr, w_tx_sr_next, w_tx_src, w_frame;
  logic [15:0] r_rx_sr, r_rsp_rdata;
  logic        r_write, r_ta_sample, r_mdc, r_mdio_o, r_mdio_t, r_rsp_valid, r_rsp_ta_err;
  logic        w_accept, w_bit_end, w_sample, w_frame_end, w_last_bit, w_load;
  logic        w_write_next, w_mdio_o_next, w_mdio_t_next;

  // Everything after the preamble, MSB first; read frames carry ones where the PHY drives.
  assign w_frame = cmd_write ? {2'b01, 2'b01, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata}
                             : {2'b01, 2'b10, cmd_phy_addr, cmd_reg_addr, 2'b11, 16'hFFFF};

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_bit_end   = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_sample    = (r_state != S_IDLE) && (r_div_cnt == DIV_SAMP);
  // The response cycle closes the IDLE bit so a new frame can start on the bit grid.
  assign w_frame_end = (r_state == S_END) && (r_div_cnt == DIV_END);

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_field_last   = 6'd0;
    case (r_state)
      S_PREAMBLE:        w_field_last = PRE_LAST;
      S_ST, S_OP, S_TA:  w_field_last = 6'd1;
      S_PHYAD, S_REGAD:  w_field_last = 6'd4;
      S_DATA:            w_field_last = 6'd15;
      default:           w_field_last = 6'd0;
    endcase
    w_last_bit = (r_bit_cnt == w_field_last);

    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_state_next   = (PREAMBLE_LEN == 0) ? S_ST : S_PREAMBLE;
        w_bit_cnt_next = 6'd0;
      end
    end else if (w_frame_end) begin
      w_state_next   = S_IDLE;
      w_bit_cnt_next = 6'd0;
    end else if (w_bit_end) begin
      if (w_last_bit) begin
        w_bit_cnt_next = 6'd0;
        case (r_state)
          S_PREAMBLE: w_state_next = S_ST;
          S_ST:       w_state_next = S_OP;
          S_OP:       w_state_next = S_PHYAD;
          S_PHYAD:    w_state_next = S_REGAD;
          S_REGAD:    w_state_next = S_TA;
          S_TA:       w_state_next = S_DATA;
          S_DATA:     w_state_next = S_END;
          default:    w_state_next = S_IDLE;
        endcase
      end else begin
        w_bit_cnt_next = r_bit_cnt + 6'd1;
      end
    end

    w_div_cnt_next = (r_state == S_IDLE || w_bit_end) ? 9'd0 : r_div_cnt + 9'd1;
    w_write_next   = w_accept ? cmd_write : r_write;
    w_tx_src       = w_accept ? w_frame : r_tx_sr;
    w_tx_sr_next   = w_tx_src;
    w_load         = w_accept || (w_bit_end && !w_frame_end);
    w_mdio_o_next  = r_mdio_o;
    w_mdio_t_next  = r_mdio_t;
    if (w_load) begin
      case (w_state_next)
        S_PREAMBLE: begin
          w_mdio_o_next = 1'b1;
          w_mdio_t_next = 1'b0;
        end
        S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA: begin
          w_mdio_o_next = w_tx_src[31];
          w_mdio_t_next = !w_write_next && (w_state_next == S_TA || w_state_next == S_DATA);
          w_tx_sr_next  = {w_tx_src[30:0], 1'b0};
        end
        default: begin
          w_mdio_o_next = 1'b1;
          w_mdio_t_next = 1'b1;
        end
      endcase
    end
    if (w_frame_end) begin
      w_mdio_o_next = 1'b1;
      w_mdio_t_next = 1'b1;
    end
  end

  always_ff @(posedge clk_int) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 6'd0;
      r_div_cnt    <= 9'd0;
      r_tx_sr      <= 32'd0;
      r_rx_sr      <= 16'd0;
      r_write      <= 1'b0;
      r_ta_sample  <= 1'b0;
      r_mdc        <= 1'b0;
      r_mdio_o     <= 1'b1;
      r_mdio_t     <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 16'd0;
      r_rsp_ta_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_div_cnt   <= w_div_cnt_next;
      r_tx_sr     <= w_tx_sr_next;
      r_write     <= w_write_next;
      r_mdio_o    <= w_mdio_o_next;
      r_mdio_t    <= w_mdio_t_next;
      r_mdc       <= (w_state_next != S_IDLE) && (w_div_cnt_next >= DIV_HALF);
      r_rsp_valid <= w_frame_end;
      if (w_sample && r_state == S_TA && r_bit_cnt == 6'd1) begin
        r_ta_sample <= mdio_i;
      end
      if (w_sample && r_state == S_DATA) begin
        r_rx_sr <= {r_rx_sr[14:0], mdio_i};
      end
      if (w_frame_end) begin
        r_rsp_rdata  <= r_write ? 16'd0 : r_rx_sr;
        r_rsp_ta_err <= !r_write && r_ta_sample;
      end
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign mdc        = r_mdc;
  assign mdio_o     = r_mdio_o;
  assign mdio_t     = r_mdio_t;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_ta_err = r_rsp_ta_err;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (CLK_DIV=2/PREAMBLE=32 and CLK_DIV=50/PREAMBLE=0),
// a PHY responder on the pad, and a bit-level frame model built from the MDIO frame rules.
module tb_mdio_master;
  localparam int D0 = 2, P0 = 32, D1 = 50, P1 = 0;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        rst, v0, v1, sel;
  logic        cmd_write;
  logic [4:0]  cmd_phy, cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rdy0, rdy1, rv0, rv1, te0, te1, bsy0, bsy1, mdc0, mdc1, o0, o1, t0, t1;
  logic [15:0] rd0, rd1;
  logic        mdio_pad;

  mdio_master #(.CLK_DIV(D0), .PREAMBLE_LEN(P0)) dut0 (
    .clk_int(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_ta_err(te0), .busy(bsy0), .mdc(mdc0),
    .mdio_i(mdio_pad), .mdio_o(o0), .mdio_t(t0));

  mdio_master #(.CLK_DIV(D1), .PREAMBLE_LEN(P1)) dut1 (
    .clk_int(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_ta_err(te1), .busy(bsy1), .mdc(mdc1),
    .mdio_i(mdio_pad), .mdio_o(o1), .mdio_t(t1));

  wire        w_mdc   = sel ? mdc1 : mdc0;
  wire        w_o     = sel ? o1 : o0;
  wire        w_t     = sel ? t1 : t0;
  wire        w_ready = sel ? rdy1 : rdy0;
  wire        w_valid = sel ? v1 : v0;
  wire        w_busy  = sel ? bsy1 : bsy0;
  wire        w_rsp   = sel ? rv1 : rv0;
  wire [15:0] w_rd    = sel ? rd1 : rd0;
  wire        w_te    = sel ? te1 : te0;

  // PHY responder state and pad with pull-up
  logic        phy_en = 1'b0, phy_val = 1'b1, cur_wr = 1'b1;
  logic        m_resp, m_ta2;
  logic [15:0] m_data;
  assign mdio_pad = phy_en ? phy_val : (w_t ? 1'b1 : w_o);

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rec_o[$], rec_t[$];
  int   rise_cyc[$], acc_q[$], rsp_q[$];
  logic [15:0] rd_q[$];
  logic te_q[$];
  logic prev_mdc = 1'b0;

  // Observe on the falling edge: accepts, mdc rises (bit values), responses; drive PHY bits.
  always @(negedge clk) begin
    int k, p;
    p = sel ? P1 : P0;
    if (!rst && w_valid && w_ready) begin
      acc_q.push_back(cyc);
      rec_o.delete(); rec_t.delete(); rise_cyc.delete();
      cur_wr = cmd_write;
      phy_en = 1'b0;
    end
    if (w_mdc && !prev_mdc) begin
      rec_o.push_back(w_o);
      rec_t.push_back(w_t);
      rise_cyc.push_back(cyc);
      k = rec_o.size();
      if (m_resp && !cur_wr && k >= p + 15 && k <= p + 31) begin
        phy_en  = 1'b1;
        phy_val = (k == p + 15) ? m_ta2 : m_data[15 - (k - p - 16)];
      end else begin
        phy_en = 1'b0;
      end
    end
    if (w_rsp) begin
      rsp_q.push_back(cyc);
      rd_q.push_back(w_rd);
      te_q.push_back(w_te);
    end
    prev_mdc = w_mdc;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit s, input logic val);
    if (s) v1 = val; else v0 = val;
  endtask

  // Reference frame: the bit sequence a Clause-22 frame must carry, plus which bits are driven.
  task automatic model_frame(input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] wd, input int p,
                             output logic [79:0] eo, output logic [79:0] et, output int n);
    logic qo[$], qt[$];
    logic [15:0] fld;
    repeat (p) begin qo.push_back(1'b1); qt.push_back(1'b0); end
    fld = wr ? 16'b0101 : 16'b0110;
    for (int i = 3; i >= 0; i--) begin qo.push_back(fld[i]); qt.push_back(1'b0); end
    for (int i = 4; i >= 0; i--) begin qo.push_back(phy[i]); qt.push_back(1'b0); end
    for (int i = 4; i >= 0; i--) begin qo.push_back(ra[i]); qt.push_back(1'b0); end
    if (wr) begin
      qo.push_back(1'b1); qt.push_back(1'b0);
      qo.push_back(1'b0); qt.push_back(1'b0);
      for (int i = 15; i >= 0; i--) begin qo.push_back(wd[i]); qt.push_back(1'b0); end
    end else begin
      repeat (18) begin qo.push_back(1'b1); qt.push_back(1'b1); end
    end
    qo.push_back(1'b1); qt.push_back(1'b1);
    eo = '0; et = '0;
    n = qo.size();
    for (int i = 0; i < n; i++) begin eo[i] = qo[i]; et[i] = qt[i]; end
  endtask

  task automatic wait_accepts(input int want, input int budget, input string tag);
    int c = 0;
    while (acc_q.size() < want && c < budget) begin @(posedge clk); #1; c++; end
    if (acc_q.size() < want) chk({tag, ".accept_timeout"}, acc_q.size(), want);
  endtask

  task automatic wait_rsps(input int want, input int budget);
    int c = 0;
    while (rsp_q.size() < want && c < budget) begin @(posedge clk); #1; c++; end
  endtask

  task automatic clear_obs();
    acc_q.delete(); rsp_q.delete(); rd_q.delete(); te_q.delete();
  endtask

  task automatic run_cmd(input bit s, input bit wr, input logic [4:0] phy, input logic [4:0] ra,
                         input logic [15:0] wd, input bit resp, input bit ta2,
                         input logic [15:0] pdata, input string tag);
    int p, d, n, bad, lat;
    logic [79:0] eo, et, ro, rt, mk;
    logic [15:0] exp_rd;
    logic exp_te;
    p = s ? P1 : P0;
    d = s ? D1 : D0;
    sel = s; m_resp = resp; m_ta2 = ta2; m_data = pdata;
    clear_obs();
    @(posedge clk); #1;
    cmd_write = wr; cmd_phy = phy; cmd_reg = ra; cmd_wdata = wd;
    set_valid(s, 1'b1);
    wait_accepts(1, 10, tag);
    set_valid(s, 1'b0);
    // Mid-frame command with different fields must be ignored and must not disturb the frame.
    repeat (20) @(posedge clk);
    #1;
    cmd_write = 1'($urandom); cmd_phy = 5'($urandom); cmd_reg = 5'($urandom);
    cmd_wdata = 16'($urandom);
    set_valid(s, 1'b1);
    @(posedge clk); #1;
    set_valid(s, 1'b0);
    wait_rsps(1, (p + 33) * 2 * d + 40);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".accepts"}, acc_q.size(), 1);
    chk({tag, ".rsp_count"}, rsp_q.size(), 1);
    lat = (rsp_q.size() > 0 && acc_q.size() > 0) ? rsp_q[0] - acc_q[0] : -1;
    chk({tag, ".latency"}, lat, (p + 33) * 2 * d);
    exp_rd = wr ? 16'h0 : (resp ? pdata : 16'hFFFF);
    exp_te = wr ? 1'b0 : (resp ? ta2 : 1'b1);
    chk({tag, ".rdata"}, (rd_q.size() > 0) ? rd_q[0] : 16'hDEAD, exp_rd);
    chk({tag, ".ta_err"}, (te_q.size() > 0) ? te_q[0] : 1'bx, exp_te);
    model_frame(wr, phy, ra, wd, p, eo, et, n);
    chk({tag, ".bits"}, rec_o.size(), n);
    ro = '0; rt = '0;
    for (int i = 0; i < rec_o.size() && i < 80; i++) begin ro[i] = rec_o[i]; rt[i] = rec_t[i]; end
    mk = ~et;
    for (int i = n; i < 80; i++) mk[i] = 1'b0;
    chk({tag, ".mdio_o"}, ro & mk, eo & mk);
    chk({tag, ".mdio_t"}, rt, et);
    bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != 2 * d) bad++;
    chk({tag, ".mdc_period"}, bad, 0);
    $display("txn %s: wr=%0d phy=%0h reg=%0h wdata=%04h -> rdata=%04h ta_err=%0d latency=%0d",
             tag, wr, phy, ra, wd, (rd_q.size() > 0) ? rd_q[0] : 16'h0,
             (te_q.size() > 0) ? te_q[0] : 1'b0, lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rdata_b2b;
    int c;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; sel = 1'b0;
    cmd_write = 1'b0; cmd_phy = 5'd0; cmd_reg = 5'd0; cmd_wdata = 16'd0;
    m_resp = 1'b0; m_ta2 = 1'b0; m_data = 16'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset.inst0", {rdy0, bsy0, rv0, rd0, te0, mdc0, o0, t0}, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    chk("reset.inst1", {rdy1, bsy1, rv1, rd1, te1, mdc1, o1, t1}, {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst = 1'b0;

    run_cmd(0, 1'b1, 5'd0, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0, "wr_1140");
    run_cmd(0, 1'b0, 5'd0, 5'h02, 16'h0, 1'b1, 1'b0, 16'h4F51, "rd_4f51");
    run_cmd(0, 1'b0, 5'd0, 5'h02, 16'h0, 1'b0, 1'b0, 16'h0, "rd_nophy");

    // Back-to-back: valid held, second command accepted on the first response cycle.
    sel = 1'b0; m_resp = 1'b1; m_ta2 = 1'b0; rdata_b2b = 16'($urandom); m_data = rdata_b2b;
    clear_obs();
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_phy = 5'd3; cmd_reg = 5'd4; cmd_wdata = 16'h00FF; v0 = 1'b1;
    wait_accepts(1, 10, "b2b1");
    cmd_write = 1'b0; cmd_phy = 5'd5; cmd_reg = 5'd6;
    wait_accepts(2, 600, "b2b2");
    v0 = 1'b0;
    wait_rsps(2, 600);
    #1;
    chk("b2b.accept_gap", (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1, 260);
    chk("b2b.accept_on_rsp", (acc_q.size() > 1 && rsp_q.size() > 0) ? acc_q[1] - rsp_q[0] : -1, 0);
    chk("b2b.rsp_count", rsp_q.size(), 2);
    chk("b2b.rsp2_latency", (rsp_q.size() > 1 && acc_q.size() > 1) ? rsp_q[1] - acc_q[1] : -1, 260);
    chk("b2b.wr_rdata", (rd_q.size() > 0) ? rd_q[0] : 16'hDEAD, 16'h0);
    chk("b2b.rd_rdata", (rd_q.size() > 1) ? rd_q[1] : 16'hDEAD, rdata_b2b);
    chk("b2b.rd_ta_err", (te_q.size() > 1) ? te_q[1] : 1'bx, 1'b0);
    $display("txn b2b: accepts gap=%0d rdata=%04h", (acc_q.size() > 1) ? acc_q[1] - acc_q[0] : -1,
             (rd_q.size() > 1) ? rd_q[1] : 16'h0);

    // Reset during bit 40 of a write abandons the frame with no response.
    repeat (5) @(posedge clk);
    clear_obs();
    m_resp = 1'b0;
    @(posedge clk); #1;
    cmd_write = 1'b1; cmd_phy = 5'd1; cmd_reg = 5'd9; cmd_wdata = 16'hBEEF; v0 = 1'b1;
    wait_accepts(1, 10, "rst");
    v0 = 1'b0;
    c = 0;
    while (rec_o.size() < 41 && c < 400) begin @(posedge clk); #1; c++; end
    chk("rst.reached_bit40", rec_o.size(), 41);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.next_cycle", {mdc0, t0, rdy0, bsy0}, 4'b0110);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    chk("rst.no_rsp", rsp_q.size(), 0);
    $display("txn rst_mid_frame: responses after reset=%0d", rsp_q.size());
    run_cmd(0, 1'b0, 5'd3, 5'h01, 16'h0, 1'b1, 1'b0, 16'hA5C3, "rd_after_rst");

    run_cmd(1, 1'b0, 5'd1, 5'h01, 16'h0, 1'b1, 1'b0, 16'($urandom), "p0_rd");
    run_cmd(1, 1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, "p0_wr_rand");

    for (int i = 0; i < 4; i++) begin
      run_cmd(0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
              1'($urandom), 1'($urandom), 16'($urandom), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
